// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op codes, exception codes and FSM state encodings.
// The `define block is the shared header content; the package re-exports it
// as typed constants for code that imports e_mdu_pkg.
`ifndef E_MDU_PARAMETERS_V
`define E_MDU_PARAMETERS_V
`define MDU_MULT   3'd0
`define MDU_MULTU  3'd1
`define MDU_DIV    3'd2
`define MDU_DIVU   3'd3
`define MDU_MTHI   3'd4
`define MDU_MTLO   3'd5
`define Ov         5'd12
`define MDU_S_IDLE 2'd0
`define MDU_S_MUL  2'd1
`define MDU_S_DIV  2'd2
`endif

package e_mdu_pkg;
  typedef enum logic [1:0] {
    S_IDLE = `MDU_S_IDLE,
    S_MUL  = `MDU_S_MUL,
    S_DIV  = `MDU_S_DIV
  } state_e;

  localparam logic [2:0] OP_MULT  = `MDU_MULT;
  localparam logic [2:0] OP_MULTU = `MDU_MULTU;
  localparam logic [2:0] OP_DIV   = `MDU_DIV;
  localparam logic [2:0] OP_DIVU  = `MDU_DIVU;
  localparam logic [2:0] OP_MTHI  = `MDU_MTHI;
  localparam logic [2:0] OP_MTLO  = `MDU_MTLO;
  localparam logic [4:0] EXC_OV   = `Ov;
endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider: quotient truncates toward zero,
// remainder follows the dividend's sign. Zero divisor yields all-ones/A,
// signed MIN / -1 yields MIN remainder 0.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, uq, ur;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  // Magnitude divide; the result is ignored when the divisor is zero.
  assign uq    = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign ur    = (b_mag == '0) ? '0 : a_mag % b_mag;

  // Apply special-case rules, then restore signs on the magnitude result.
  always_comb begin
    quot_o = (a_neg ^ b_neg) ? -uq : uq;
    rem_o  = a_neg ? -ur : ur;
    if (b_i == '0) begin
      quot_o = '1;
      rem_o  = a_i;
    end else if (signed_i && a_i == MIN && b_i == '1) begin
      quot_o = MIN;
      rem_o  = '0;
    end
  end
endmodule

// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers and fixed-latency busy window.
// Optional macro MDU_DIVZERO_EXC_EN: reject div/divu by zero with an Ov
// exception pulse instead of running the divide.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             exception,
  output logic [4:0]       exception_type
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, exc_q, exc_d;
  logic [4:0]       exct_q, exct_d;

  logic               accept, div_rej;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   quot, rem;

  assign accept = start && !flush && (state_q == S_IDLE);
`ifdef MDU_DIVZERO_EXC_EN
  assign div_rej = (B == '0);
`else
  assign div_rej = 1'b0;
`endif

  // Product from latched operands; low 2*WIDTH bits are exact for both signednesses.
  assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .a_i     (a_q),
    .b_i     (b_q),
    .signed_i(sgn_q),
    .quot_o  (quot),
    .rem_o   (rem)
  );

  // Next-state: launch from IDLE, count down the busy window, commit or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    exc_d   = 1'b0;
    exct_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CW'(MUL_CYCLES - 1);
              a_d     = A;
              b_d     = B;
              sgn_d   = (mdu_op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              if (div_rej) begin
                exc_d  = 1'b1;
                exct_d = EXC_OV;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(DIV_CYCLES - 1);
                a_d     = A;
                b_d     = B;
                sgn_d   = (mdu_op == OP_DIV);
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (state_q == S_MUL) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      exc_q   <= 1'b0;
      exct_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      exc_q   <= exc_d;
      exct_q  <= exct_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign exception      = exc_q;
  assign exception_type = exct_q;
endmodule
